// File: rtl/gat_feat_reader_if.sv
// Output stream of the new-feature readback path: data word plus node/frame delimiters.
interface gat_feat_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              m_eof;

    modport master (output m_data, m_valid, m_last, m_eof, input m_ready);
    modport slave  (input m_data, m_valid, m_last, m_eof, output m_ready);
endinterface

// File: rtl/gat_feat_reader.sv
// Sweeps the GAT new-feature BRAM once per start and streams the words out with node/frame delimiters.
// Optional macro GAT_FEAT_READER_RELU_EN clamps negative output words to zero.
module gat_feat_reader #(
    parameter int NEW_FEATURE_WIDTH  = 8,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    gat_feat_reader_if.master             strm,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int ADDR_W = NEW_FEATURE_ADDR_W;
    localparam int W      = NEW_FEATURE_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [FEAT_W-1:0] LAST_FEAT = FEAT_W'(NUM_FEATURE_OUT - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("gat_feat_reader: RD_LATENCY must be within 1..4");
    end
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_fifo
        $error("gat_feat_reader: FIFO_DEPTH must be at least RD_LATENCY+1");
    end

    typedef enum logic [2:0] {IDLE, WAIT_RDY, READ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic                issue, push, pop, eof_xfer, credit_ok;
    logic [RD_LATENCY:0] vld_pipe;
    logic [ADDR_W-1:0]   issue_idx, issue_addr, out_idx;
    logic [FEAT_W-1:0]   feat_idx;
    logic [CNT_W-1:0]    in_flight, fifo_count;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [W-1:0]        mem [FIFO_DEPTH];
    logic [W-1:0]        head, head_out;

    // vld_pipe[0] rises with the address register; vld_pipe[RD_LATENCY] lines up with valid dout.
    assign push = vld_pipe[RD_LATENCY];
    assign pop  = strm.m_valid & strm.m_ready;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) in_flight = in_flight + CNT_W'(vld_pipe[i]);
    end

    // A word leaving the FIFO this cycle frees its slot, which keeps the loop at one word per cycle.
    assign credit_ok  = (in_flight + fifo_count) < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop));
    assign issue_addr = (state == WAIT_RDY) ? '0 : issue_idx;
    assign eof_xfer   = pop & (out_idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = WAIT_RDY;
            // Word 0 goes out on the transition so the first m_valid lands RD_LATENCY+1 cycles into READ.
            WAIT_RDY: if (gat_ready) begin
                issue     = 1'b1;
                state_nxt = READ;
            end
            READ:     if (credit_ok) begin
                issue = 1'b1;
                if (issue_idx == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN:    if (eof_xfer) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            vld_pipe        <= '0;
            feat_bram_addrb <= '0;
            issue_idx       <= '0;
            err             <= 1'b0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue};
            if (issue) begin
                feat_bram_addrb <= {issue_addr, 2'b00};
                issue_idx       <= issue_addr + ADDR_W'(1);
            end
            if (state == WAIT_RDY && gat_ready)
                err <= 1'b0;
            else if ((state == READ || state == DRAIN) && !gat_ready)
                err <= 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= feat_bram_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx  <= '0;
            feat_idx <= '0;
        end else if (pop) begin
            out_idx  <= eof_xfer ? '0 : out_idx + ADDR_W'(1);
            feat_idx <= (eof_xfer || feat_idx == LAST_FEAT) ? '0 : feat_idx + FEAT_W'(1);
        end
    end

    assign head = mem[rd_ptr];
`ifdef GAT_FEAT_READER_RELU_EN
    assign head_out = head[W-1] ? '0 : head;
`else
    assign head_out = head;
`endif

    // Outputs are gated by m_valid so everything reads 0 while the FIFO is empty or in reset.
    assign strm.m_valid = (fifo_count != '0);
    assign strm.m_data  = strm.m_valid ? head_out : '0;
    assign strm.m_last  = strm.m_valid & (feat_idx == LAST_FEAT);
    assign strm.m_eof   = strm.m_valid & (out_idx == LAST_IDX);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_gat_feat_reader.sv
// Scoreboard bench for gat_feat_reader: 3 nodes x 4 features, RD_LATENCY 2, BRAM word i = i+1.
module tb_gat_feat_reader;
    localparam int W     = 8;
    localparam int NFO   = 4;
    localparam int NSG   = 3;
    localparam int DEPTH = NSG * NFO;
    localparam int AW    = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          gat_ready = 1'b0;
    logic [AW+1:0] addrb;
    logic [W-1:0]  dout;
    logic          busy, done, err;

    gat_feat_reader_if #(.DATA_W(W)) strm ();

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NFO), .NUM_SUBGRAPHS(NSG),
        .RD_LATENCY(LAT), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .gat_ready(gat_ready),
        .feat_bram_addrb(addrb), .feat_bram_dout(dout), .strm(strm),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM model: address visible in cycle T gives data in cycle T+2.
    logic [W-1:0] bram [DEPTH];
    logic [W-1:0] d1;
    always @(posedge clk) begin
        d1   <= bram[addrb[AW+1:2]];
        dout <= d1;
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         eof;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    bit bp_mode = 0;
    int phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // m_ready pattern under backpressure: 1,0,0,1 repeating.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            strm.m_ready = (phase % 4 == 0) || (phase % 4 == 3);
            phase++;
        end else begin
            strm.m_ready = 1'b1;
        end
    end

    logic stall_prev = 1'b0;
    logic eof_prev = 1'b0;
    exp_t held;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            eof_prev   = 1'b0;
        end else begin
            chk("credit_le_4", 32'((32'(dut.in_flight) + 32'(dut.fifo_count)) <= 4), 32'd1);
            if (stall_prev) begin
                chk("stall_valid", 32'(strm.m_valid), 32'd1);
                chk("stall_hold", 32'({strm.m_data, strm.m_last, strm.m_eof}), 32'(held));
            end
            if (eof_prev) chk("done_after_eof", 32'(done), 32'd1);
            else if (done) chk("unexpected_done", 32'(done), 32'd0);
            eof_prev = 1'b0;
            if (strm.m_valid && strm.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got 0x%0h, want nothing", strm.m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(strm.m_data), 32'(e.data));
                    chk("last", 32'(strm.m_last), 32'(e.last));
                    chk("eof", 32'(strm.m_eof), 32'(e.eof));
                end
                rx_cnt++;
                eof_prev = strm.m_eof;
            end
            stall_prev = strm.m_valid && !strm.m_ready;
            held = {strm.m_data, strm.m_last, strm.m_eof};
        end
    end

    task automatic push_word(input int i, input logic [W-1:0] d);
        exp_t x;
        x.data = d;
        x.last = (i % NFO == NFO - 1);
        x.eof  = (i == DEPTH - 1);
        exp_q.push_back(x);
    endtask

    // Frame data is i+1 for every word (all positive, so unaffected by clamping).
    task automatic push_frame();
        for (int i = 0; i < DEPTH; i++) push_word(i, W'(i + 1));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Called right after pulse_start with gat_ready high and m_ready held at 1.
    task automatic addr_seq();
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            chk($sformatf("addr_%0d", i), 32'(addrb), 32'(4 * i));
            chk($sformatf("first_valid_%0d", i), 32'(strm.m_valid), 32'(i >= LAT + 1));
        end
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_cnt < n && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (rx_cnt < n) timeout("wait_rx");
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) timeout("wait_done");
        @(posedge clk); #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_valid"}, 32'(strm.m_valid), 32'd0);
        chk({tag, "_data"}, 32'(strm.m_data), 32'd0);
        chk({tag, "_last"}, 32'(strm.m_last), 32'd0);
        chk({tag, "_eof"}, 32'(strm.m_eof), 32'd0);
        chk({tag, "_addr"}, 32'(addrb), 32'd0);
    endtask

    logic [W-1:0] relu_in  [3];
    logic [W-1:0] relu_out [3];
    int base;

    initial begin
        for (int i = 0; i < DEPTH; i++) bram[i] = W'(i + 1);
        relu_in[0] = 8'h85; relu_in[1] = 8'h7F; relu_in[2] = 8'hFF;
`ifdef GAT_FEAT_READER_RELU_EN
        relu_out[0] = 8'h00; relu_out[1] = 8'h7F; relu_out[2] = 8'h00;
`else
        relu_out[0] = 8'h85; relu_out[1] = 8'h7F; relu_out[2] = 8'hFF;
`endif

        repeat (3) @(posedge clk);
        #1 chk_idle("reset");
        rst = 1'b0;
        gat_ready = 1'b1;
        @(posedge clk); #1;
        chk_idle("post_reset");

        // Basic frame: consecutive addresses, first valid at RD_LATENCY+1, data 1..12.
        push_frame();
        pulse_start();
        chk("busy_on_start", 32'(busy), 32'd1);
        addr_seq();
        wait_done();
        chk("err_clean", 32'(err), 32'd0);

        // Backpressure.
        bp_mode = 1;
        push_frame();
        pulse_start();
        wait_done();
        bp_mode = 0;

        // Gated start, plus a start pulse during READ that must be ignored.
        gat_ready = 1'b0;
        push_frame();
        pulse_start();
        chk("gated_busy", 32'(busy), 32'd1);
        repeat (10) begin @(posedge clk); #1; end
        chk("gated_addr_hold", 32'(addrb), 32'd44);
        chk("gated_no_valid", 32'(strm.m_valid), 32'd0);
        gat_ready = 1'b1;
        @(posedge clk); #1;
        chk("gated_first_addr", 32'(addrb), 32'd0);
        base = rx_cnt;
        wait_rx(base + 2);
        pulse_start();
        wait_done();
        repeat (5) begin @(posedge clk); #1; end
        chk("start_in_read_ignored", 32'(busy), 32'd0);

        // gat_ready dropped for one cycle at word 5.
        push_frame();
        pulse_start();
        base = rx_cnt;
        wait_rx(base + 5);
        gat_ready = 1'b0;
        @(posedge clk); #1 gat_ready = 1'b1;
        chk("err_set", 32'(err), 32'd1);
        wait_done();
        chk("err_sticky", 32'(err), 32'd1);

        // Clamping frame; also err must clear on entering READ.
        for (int i = 0; i < 3; i++) bram[i] = relu_in[i];
        for (int i = 0; i < DEPTH; i++) push_word(i, (i < 3) ? relu_out[i] : W'(i + 1));
        pulse_start();
        chk("err_before_read", 32'(err), 32'd1);
        @(posedge clk); #1;
        chk("err_cleared", 32'(err), 32'd0);
        wait_done();
        for (int i = 0; i < 3; i++) bram[i] = W'(i + 1);

        // Asynchronous reset at word 7.
        push_frame();
        pulse_start();
        base = rx_cnt;
        wait_rx(base + 7);
        #1 rst = 1'b1;
        #1 chk_idle("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midreset_no_done", 32'(done), 32'd0);
        chk("midreset_idle", 32'(busy), 32'd0);

        // Fresh frame after reset starts again from address 0.
        push_frame();
        pulse_start();
        addr_seq();
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
